// File: rtl/alu_resp_unit_if.sv
// alu_resp_unit_if
//   Request/response bundle for the ALU responder.
//   Parameters WIDTH / DEPTH / TAG_W must match those of the attached
//   alu_resp_unit instance.
//   master : initiator side (drives requests, consumes responses)
//   slave  : responder side (alu_resp_unit)
//   Signals:
//     req_valid_i / req_ready_o        request handshake
//     a_i, b_i, op_i, tag_i            request payload
//     rsp_valid_o / rsp_ready_i        response handshake
//     rsp_data_o, rsp_tag_o            head-of-queue result and tag
//     count_o                          queue occupancy
//     rsp_flags_o                      {carry, zero}, only with ALU_RESP_FLAGS_EN
interface alu_resp_unit_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             req_valid_i;
    logic             req_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [2:0]       op_i;
    logic [TAG_W-1:0] tag_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [WIDTH-1:0] rsp_data_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic [CNT_W-1:0] count_o;
`ifdef ALU_RESP_FLAGS_EN
    logic [1:0]       rsp_flags_o;
`endif

    modport master (
        output req_valid_i, a_i, b_i, op_i, tag_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_tag_o, count_o
`ifdef ALU_RESP_FLAGS_EN
        , input rsp_flags_o
`endif
    );

    modport slave (
        input  req_valid_i, a_i, b_i, op_i, tag_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_tag_o, count_o
`ifdef ALU_RESP_FLAGS_EN
        , output rsp_flags_o
`endif
    );
endinterface

// File: rtl/alu_resp_unit.sv
// alu_resp_unit
//   Handshaked 8-bit (WIDTH) ALU responder. Each accepted request is
//   evaluated combinationally and its result written into a DEPTH-entry
//   response FIFO on the accepting edge; results leave in request order.
//   Ports:
//     clk      single rising-edge clock
//     reset_n  synchronous active-low reset (flushes the FIFO)
//     bus      alu_resp_unit_if.slave (request/response channels, count_o)
//   Optional build macro ALU_RESP_FLAGS_EN adds per-entry {carry, zero}
//   flags presented on bus.rsp_flags_o.
module alu_resp_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_resp_unit_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SH_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_SLL = 3'b010,
        OP_LSR = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_EQL = 3'b111
    } op_e;

    // FIFO storage; contents need no reset because outputs are gated by count.
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];
`ifdef ALU_RESP_FLAGS_EN
    logic [1:0]       flag_mem [DEPTH];
    logic [1:0]       alu_flags;
`endif

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             empty;
    logic             full;
    logic             req_ready;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] alu_res;

    // ---------------------------------------------------------------
    // Handshake qualification
    // ---------------------------------------------------------------
    always_comb begin
        empty     = (count == '0);
        full      = (count == FULL_CNT);
        // No bypass at full: a same-cycle pop never frees a slot for the push.
        req_ready = !full && reset_n;
        push      = bus.req_valid_i && req_ready;
        pop       = !empty && bus.rsp_ready_i;
    end

    // ---------------------------------------------------------------
    // ALU datapath
    // ---------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        case (op_e'(bus.op_i))
            OP_ADD:  alu_res = bus.a_i + bus.b_i;
            OP_SUB:  alu_res = bus.a_i - bus.b_i;
            OP_SLL:  alu_res = bus.a_i << bus.b_i[SH_W-1:0];
            OP_LSR:  alu_res = bus.a_i >> bus.b_i[SH_W-1:0];
            OP_AND:  alu_res = bus.a_i & bus.b_i;
            OP_OR:   alu_res = bus.a_i | bus.b_i;
            OP_XOR:  alu_res = bus.a_i ^ bus.b_i;
            OP_EQL:  alu_res = {{(WIDTH-1){1'b0}}, (bus.a_i == bus.b_i)};
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_RESP_FLAGS_EN
    always_comb begin
        alu_flags = 2'b00;
        case (op_e'(bus.op_i))
            // Unsigned add overflowed exactly when the wrapped sum is below an operand.
            OP_ADD:  alu_flags[1] = (alu_res < bus.a_i);
            OP_SUB:  alu_flags[1] = (bus.a_i < bus.b_i);
            default: alu_flags[1] = 1'b0;
        endcase
        alu_flags[0] = (alu_res == '0);
    end
`endif

    // ---------------------------------------------------------------
    // FIFO write port
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= alu_res;
            tag_mem[wr_ptr]  <= bus.tag_i;
`ifdef ALU_RESP_FLAGS_EN
            flag_mem[wr_ptr] <= alu_flags;
`endif
        end
    end

    // ---------------------------------------------------------------
    // Pointers and occupancy
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally at DEPTH (power of two).
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Outputs: driven only from registered state, so no request-to-response
    // combinational path exists. Empty forces data/tag/flags to zero.
    // ---------------------------------------------------------------
    always_comb begin
        bus.req_ready_o = req_ready;
        bus.rsp_valid_o = !empty;
        bus.count_o     = count;
        bus.rsp_data_o  = empty ? '0 : data_mem[rd_ptr];
        bus.rsp_tag_o   = empty ? '0 : tag_mem[rd_ptr];
`ifdef ALU_RESP_FLAGS_EN
        bus.rsp_flags_o = empty ? 2'b00 : flag_mem[rd_ptr];
`endif
    end

endmodule
